// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bundle: instruction-memory handshake, decode-facing
// outputs and the execute-stage redirect inputs.
interface fetch_sequencer_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
);
   // instruction memory handshake
   logic               out_imem_req;
   logic [PC_W-1:0]    out_imem_addr;
   logic               in_imem_ack;
   logic [INSTR_W-1:0] in_imem_rdata;

   // decode side
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_instr_pc;
   logic [3:0]         out_opcode;
   logic               out_valid;
   logic               in_stall;

   // redirect from execute
   logic               in_ctrl_jump;
   logic               in_ctrl_branch;
   logic               in_ctrl_btype;
   logic               in_flag_z;
   logic               in_flag_n;
   logic [PC_W-1:0]    in_target;

   // fetch sequencer side
   modport master (
      output out_imem_req, out_imem_addr,
      input  in_imem_ack, in_imem_rdata,
      output out_instr, out_instr_pc, out_opcode, out_valid,
      input  in_stall,
      input  in_ctrl_jump, in_ctrl_branch, in_ctrl_btype,
      input  in_flag_z, in_flag_n, in_target
   );

   // memory / decode / execute side
   modport slave (
      input  out_imem_req, out_imem_addr,
      output in_imem_ack, in_imem_rdata,
      input  out_instr, out_instr_pc, out_opcode, out_valid,
      output in_stall,
      output in_ctrl_jump, in_ctrl_branch, in_ctrl_btype,
      output in_flag_z, in_flag_n, in_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: single-outstanding request/ack to instruction
// memory, one-entry skid buffer behind the decode register, and PC redirect
// from execute-stage jump/branch resolution.
module fetch_sequencer #(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               in_clk,
   input  logic               in_rst,
   fetch_sequencer_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,   // no request; next cycle starts fetching
      FETCH,  // request at fetch_addr outstanding
      DRAIN,  // waiting out a request made obsolete by a redirect
      FULL    // decode register and skid buffer both occupied
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
   logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [PC_W-1:0]    out_pc_q, out_pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
   logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
   logic               pend_valid_q, pend_valid_d;

   logic redirect;
   logic transfer;

   // Resolve redirect and decode handshake for this cycle.
   always_comb begin
      redirect = bus.in_ctrl_jump |
                 (bus.in_ctrl_branch & (bus.in_ctrl_btype ? bus.in_flag_n : bus.in_flag_z));
      transfer = out_valid_q & ~bus.in_stall;
   end

   // Next-state and datapath update; redirect overrides everything else.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned; otherwise the tool infers a latch.
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      drain_addr_d = drain_addr_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      out_valid_d  = out_valid_q;
      pend_instr_d = pend_instr_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;

      // Decode consumed the presented word: refill from the skid buffer.
      if (transfer) begin
         if (pend_valid_q) begin
            out_instr_d  = pend_instr_q;
            out_pc_d     = pend_pc_q;
            pend_valid_d = 1'b0;
         end else begin
            out_valid_d  = 1'b0;
         end
      end

      if (redirect) begin
         out_valid_d  = 1'b0;
         pend_valid_d = 1'b0;
         fetch_addr_d = bus.in_target;
         unique case (state_q)
            FETCH: begin
               if (bus.in_imem_ack) begin
                  state_d = FETCH;
               end else begin
                  state_d      = DRAIN;
                  drain_addr_d = fetch_addr_q;
               end
            end
            DRAIN:   state_d = bus.in_imem_ack ? FETCH : DRAIN;
            default: state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (bus.in_imem_ack) begin
                  fetch_addr_d = fetch_addr_q + PC_W'(1);
                  // The skid buffer is only ever occupied in FULL, so here a
                  // returning word lands in out or, if out is held, in pend.
                  if (!out_valid_q || transfer) begin
                     out_instr_d = bus.in_imem_rdata;
                     out_pc_d    = fetch_addr_q;
                     out_valid_d = 1'b1;
                  end else begin
                     pend_instr_d = bus.in_imem_rdata;
                     pend_pc_d    = fetch_addr_q;
                     pend_valid_d = 1'b1;
                     state_d      = FULL;
                  end
               end
            end
            DRAIN: begin
               if (bus.in_imem_ack) state_d = FETCH;
            end
            FULL: begin
               if (transfer) state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control and decode-register state with synchronous reset.
   always_ff @(posedge in_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (in_rst) begin
         state_q      <= IDLE;
         fetch_addr_q <= RESET_PC;
         out_instr_q  <= '0;
         out_pc_q     <= '0;
         out_valid_q  <= 1'b0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
         out_valid_q  <= out_valid_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Payload-only registers, qualified by their valid bits or state.
   always_ff @(posedge in_clk) begin
      // NOTE: these carry no reset; they are never observed until a valid
      // bit or the DRAIN state qualifies them, so resetting them buys nothing.
      drain_addr_q <= drain_addr_d;
      pend_instr_q <= pend_instr_d;
      pend_pc_q    <= pend_pc_d;
   end

   // Drive the memory request and decode-facing outputs.
   always_comb begin
      bus.out_imem_req  = (state_q == FETCH) || (state_q == DRAIN);
      bus.out_imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_addr_q;
      bus.out_instr     = out_instr_q;
      bus.out_instr_pc  = out_pc_q;
      bus.out_valid     = out_valid_q;
      bus.out_opcode    = out_valid_q ? out_instr_q[INSTR_W-1 -: 4] : 4'b0000;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven cycle vectors for the
// streaming/stall cases, hand sequences for redirect, drain, reset and wrap,
// and a scoreboard of fetched words checked whenever decode consumes one.
module tb_fetch_sequencer;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   logic in_clk = 1'b0;
   logic in_rst;

   always #5 in_clk = ~in_clk;

   fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_sequencer #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .RESET_PC ('0)
   ) dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .bus    (bus)
   );

   typedef struct {
      logic        rst;
      logic        ack;
      logic        stall;
      logic        jump;
      logic        branch;
      logic        btype;
      logic        fz;
      logic        fn;
      logic [31:0] target;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        pre_rst;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [3:0]  e_op;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   sb_t  sb_q[$];
   logic discard  = 1'b0;

   localparam int NV = 17;
   vec_t vecs[NV];

   // Instruction memory contents.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd0:   mem_word = 32'h4000_0000;
         32'd1:   mem_word = 32'h7000_0001;
         32'd2:   mem_word = 32'h5000_0002;
         default: mem_word = {a[3:0] ^ 4'hA, a[27:0]};
      endcase
   endfunction

   function automatic stim_t mk(input logic ack, input logic stall);
      stim_t s;
      s = '{default: '0};
      s.ack   = ack;
      s.stall = stall;
      return s;
   endfunction

   function automatic stim_t mk_ctl(input logic ack, input logic jump, input logic branch,
                                    input logic btype, input logic fz, input logic fn,
                                    input logic [31:0] target);
      stim_t s;
      s = mk(ack, 1'b0);
      s.jump   = jump;
      s.branch = branch;
      s.btype  = btype;
      s.fz     = fz;
      s.fn     = fn;
      s.target = target;
      return s;
   endfunction

   function automatic vec_t row(input logic pre_rst, input logic ack, input logic stall,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [3:0] e_op);
      vec_t v;
      v.s       = mk(ack, stall);
      v.pre_rst = pre_rst;
      v.e_req   = e_req;
      v.e_addr  = e_addr;
      v.e_valid = e_valid;
      v.e_pc    = e_pc;
      v.e_op    = e_op;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge, then at the
   // falling edge update the scoreboard from what the DUT shows.
   task automatic step(input stim_t s);
      logic redir;
      sb_t  e;
      in_rst             = s.rst;
      bus.in_imem_ack    = s.ack;
      bus.in_imem_rdata  = s.ack ? mem_word(bus.out_imem_addr) : 32'hDEAD_BEEF;
      bus.in_stall       = s.stall;
      bus.in_ctrl_jump   = s.jump;
      bus.in_ctrl_branch = s.branch;
      bus.in_ctrl_btype  = s.btype;
      bus.in_flag_z      = s.fz;
      bus.in_flag_n      = s.fn;
      bus.in_target      = s.target;
      @(negedge in_clk);
      redir = s.jump | (s.branch & (s.btype ? s.fn : s.fz));
      if (s.rst) begin
         sb_q.delete();
         discard = 1'b0;
      end else begin
         if (redir) begin
            sb_q.delete();
         end else if (bus.out_valid && !s.stall) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("sb_pc", bus.out_instr_pc, e.pc);
               check("sb_instr", bus.out_instr, e.instr);
            end
         end
         if (bus.out_imem_req && s.ack) begin
            if (!redir && !discard)
               sb_q.push_back('{bus.out_imem_addr, mem_word(bus.out_imem_addr)});
            discard = 1'b0;
         end else if (redir && bus.out_imem_req) begin
            discard = 1'b1;
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge in_clk);
      #1;
   endtask

   task automatic do_reset();
      stim_t s;
      s = mk(1'b0, 1'b0);
      s.rst = 1'b1;
      repeat (2) begin
         step(s);
         next_cycle();
      end
   endtask

   task automatic expect_bus(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic [3:0] op);
      check({tag, "_req"}, {31'd0, bus.out_imem_req}, {31'd0, req});
      if (req) check({tag, "_addr"}, bus.out_imem_addr, addr);
      check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, valid});
      if (valid) check({tag, "_pc"}, bus.out_instr_pc, pc);
      check({tag, "_opcode"}, {28'd0, bus.out_opcode}, {28'd0, op});
   endtask

   initial begin
      stim_t s;

      // Streaming with ack every cycle, then the stall/skid case.
      vecs[0]  = row(1, 0, 0, 0, 0, 0, 0, 4'h0);
      vecs[1]  = row(0, 1, 0, 1, 0, 0, 0, 4'h0);
      vecs[2]  = row(0, 1, 0, 1, 1, 1, 0, 4'h4);
      vecs[3]  = row(0, 1, 0, 1, 2, 1, 1, 4'h7);
      vecs[4]  = row(0, 1, 0, 1, 3, 1, 2, 4'h5);
      vecs[5]  = row(0, 0, 0, 1, 4, 1, 3, 4'h9);
      vecs[6]  = row(1, 0, 0, 0, 0, 0, 0, 4'h0);
      vecs[7]  = row(0, 1, 0, 1, 0, 0, 0, 4'h0);
      vecs[8]  = row(0, 1, 1, 1, 1, 1, 0, 4'h4);
      vecs[9]  = row(0, 0, 1, 0, 0, 1, 0, 4'h4);
      vecs[10] = row(0, 0, 1, 0, 0, 1, 0, 4'h4);
      vecs[11] = row(0, 0, 0, 0, 0, 1, 0, 4'h4);
      vecs[12] = row(0, 1, 0, 1, 2, 1, 1, 4'h7);
      vecs[13] = row(0, 0, 0, 1, 3, 1, 2, 4'h5);
      vecs[14] = row(0, 0, 0, 1, 3, 0, 0, 4'h0);
      vecs[15] = row(0, 1, 0, 1, 3, 0, 0, 4'h0);
      vecs[16] = row(0, 0, 0, 1, 4, 1, 3, 4'h9);

      in_rst = 1'b1;
      step(mk(1'b0, 1'b0));
      next_cycle();

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].pre_rst) do_reset();
         step(vecs[i].s);
         if (vecs[i].pre_rst) begin
            check($sformatf("v%0d_rst_instr", i), bus.out_instr, 32'd0);
            check($sformatf("v%0d_rst_pc", i), bus.out_instr_pc, 32'd0);
         end
         expect_bus($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_op);
         next_cycle();
      end

      // Jump with ack in the same cycle at addr 5.
      do_reset();
      step(mk(0, 0));
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         step(mk(1, 0));
         next_cycle();
      end
      step(mk_ctl(1, 1, 0, 0, 0, 0, 32'h40));
      expect_bus("h1_redir", 1, 5, 1, 4, 4'hE);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h1_flushed", 1, 32'h40, 0, 0, 4'h0);
      next_cycle();
      step(mk(1, 0));
      expect_bus("h1_fetch", 1, 32'h40, 0, 0, 4'h0);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h1_first", 1, 32'h41, 1, 32'h40, 4'hA);
      next_cycle();

      // Taken branch on zero with no ack; ack arrives three cycles later.
      step(mk_ctl(0, 0, 1, 0, 1, 0, 32'h80));
      expect_bus("h2_redir", 1, 32'h41, 0, 0, 4'h0);
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         step(mk(0, 0));
         expect_bus("h2_drain", 1, 32'h41, 0, 0, 4'h0);
         next_cycle();
      end
      step(mk(1, 0));
      expect_bus("h2_drain_ack", 1, 32'h41, 0, 0, 4'h0);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h2_refetch", 1, 32'h80, 0, 0, 4'h0);
      next_cycle();
      step(mk(1, 0));
      expect_bus("h2_fetch", 1, 32'h80, 0, 0, 4'h0);
      next_cycle();

      // Branch on negative, not taken (flag_z set to show it is ignored).
      step(mk_ctl(1, 0, 1, 1, 1, 0, 32'h200));
      expect_bus("h3_nt", 1, 32'h81, 1, 32'h80, 4'hA);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h3_seq", 1, 32'h82, 1, 32'h81, 4'hB);
      next_cycle();

      // Taken branch on negative with ack, to the top of the address space.
      step(mk_ctl(1, 0, 1, 1, 0, 1, 32'hFFFF_FFFF));
      expect_bus("h5_redir", 1, 32'h82, 0, 0, 4'h0);
      next_cycle();
      step(mk(1, 0));
      expect_bus("h5_top", 1, 32'hFFFF_FFFF, 0, 0, 4'h0);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h5_wrap", 1, 32'h0, 1, 32'hFFFF_FFFF, 4'h5);
      next_cycle();

      // Reset while draining, with a late ack right after it.
      step(mk(1, 0));
      expect_bus("h4_fetch0", 1, 0, 0, 0, 4'h0);
      next_cycle();
      step(mk_ctl(0, 1, 0, 0, 0, 0, 32'h100));
      expect_bus("h4_redir", 1, 1, 1, 0, 4'h4);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h4_drain", 1, 1, 0, 0, 4'h0);
      next_cycle();
      s = mk(0, 0);
      s.rst = 1'b1;
      step(s);
      next_cycle();
      step(mk(1, 0));
      expect_bus("h4_idle", 0, 0, 0, 0, 4'h0);
      check("h4_idle_instr", bus.out_instr, 32'd0);
      next_cycle();
      step(mk(1, 0));
      expect_bus("h4_restart", 1, 0, 0, 0, 4'h0);
      next_cycle();
      step(mk(0, 0));
      expect_bus("h4_first", 1, 1, 1, 0, 4'h4);
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch front end. It produces the 32-bit instruction whose [31:28] opcode feeds the Control decoder.
- It consumes Control's branch/jump outputs, resolved in execute, to redirect the PC.
- It runs a single-outstanding request/ack handshake to instruction memory and holds a one-entry skid buffer so decode stalls never lose a fetched word.
- It drives a NOP opcode (4'b0000: no regwrt, memrd or memwrt) whenever no valid instruction is presented.

Parameters:
PC_W, 32, width of PC / instruction address (word addressed)
INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 0, first fetch address after reset

Ports:
in_clk  input  1  clock, all state updates on rising edge
in_rst  input  1  synchronous reset, active-high
out_imem_req  output  1  fetch request; held high until in_imem_ack
out_imem_addr  output  PC_W  fetch address; stable while out_imem_req high
in_imem_ack  input  1  memory returns in_imem_rdata this cycle (may coincide with req's first cycle)
in_imem_rdata  input  INSTR_W  fetched instruction, valid only with ack
out_instr  output  INSTR_W  instruction presented to decode
out_instr_pc  output  PC_W  address of out_instr (for SVPC)
out_opcode  output  4  out_instr opcode if out_valid, else 4'b0000
out_valid  output  1  out_instr valid
in_stall  input  1  decode cannot accept; instruction held while high
in_ctrl_jump  input  1  Control jump from execute
in_ctrl_branch  input  1  Control branch from execute
in_ctrl_btype  input  1  0 = branch on zero, 1 = branch on negative
in_flag_z  input  1  ALU zero flag
in_flag_n  input  1  ALU negative flag
in_target  input  PC_W  redirect target

Behaviour:
- Redirect condition: redirect = jump | (branch & (btype ? flag_n : flag_z)), evaluated combinationally every cycle.
- Transfer: decode consumes the instruction when out_valid & !in_stall.
- Registers: fetch_addr, out_instr / out_instr_pc / out_valid, pend_instr / pend_pc / pend_valid, and state.
- States:
  - IDLE: req=0.
  - FETCH: req=1, addr=fetch_addr.
  - DRAIN: req=1, addr=the old in-flight address.
  - FULL: req=0; out and pend both valid.
- Reset (in_rst sampled high): state=IDLE, fetch_addr=RESET_PC, out_valid=0, pend_valid=0, out_instr=0, out_instr_pc=0.
  - Consequently out_opcode=0 and out_imem_req=0 in the cycle after the edge.
  - Reset mid-transaction abandons the in-flight request; a late ack while IDLE is ignored.
- IDLE -> FETCH unconditionally.
- FETCH, ack, no redirect:
  - fetch_addr += 1 (wraps modulo 2^PC_W).
  - Word goes to out if out is empty or transferring; otherwise it goes to pend and the state becomes FULL.
  - Latency: an ack in cycle N gives out_valid=1 in N+1.
- FETCH, no ack: hold addr; outputs unchanged except transfer/consumption effects.
- Consumption with pend_valid: pend moves to out on the same edge; pend_valid=0.
- FULL: stay while in_stall; on transfer move pend to out and go to FETCH.
- Redirect has priority over stall, ack and buffering. On redirect:
  - out_valid=0 and pend_valid=0; the instruction being presented is not consumed.
  - fetch_addr=in_target.
  - Next state:
    - FETCH with ack this cycle: ack data discarded, state FETCH (new addr next cycle).
    - FETCH without ack: state DRAIN.
    - DRAIN: stay DRAIN, target updated.
    - FULL or IDLE: state FETCH.
- DRAIN: keep req and the old addr until ack; discard the data; go to FETCH at fetch_addr. A redirect on the ack cycle uses the newest target.
- Never: two outstanding requests, addr change while req high, or dropped or duplicated instructions absent redirect.

Test Plan:
- Reset then ack every cycle, no stall:
  - out_imem_addr runs 0,1,2,3 on consecutive cycles.
  - out_instr_pc follows one cycle later; out_opcode 4'b0000 until the first valid.
- Memory returns 0x4..., 0x7..., 0x5... at addrs 0-2; in_stall high 3 cycles after the first valid:
  - out holds 0x4... at pc 0.
  - pend holds 0x7...; state FULL, req=0.
  - After release the sequence 0x4, 0x7, 0x5 is seen with no loss.
- Redirect with ack in the same cycle: jump=1, target=0x40 while FETCH at addr 5:
  - Ack data dropped; out_valid=0.
  - Next req addr=0x40; first valid has out_instr_pc=0x40.
- Redirect without ack: branch=1, btype=0, flag_z=1, target=0x80 with ack delayed 3 cycles:
  - req stays at the old addr (DRAIN); returned word discarded.
  - Then req addr=0x80.
- Not-taken branch: branch=1, btype=1, flag_n=0 -> no flush; sequential addresses continue.
- in_rst high during DRAIN, late ack next cycle -> ack ignored; fetch restarts at RESET_PC; fetch_addr wrap at 0xFFFFFFFF -> 0x00000000.
